// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the hazard unit and its multi-cycle hold FSM
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] LOAD_SRC_DEF = 2'b01;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_t;

    // M-stage result wins over W-stage; a non-matching or non-writing stage never forwards.
    function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
        if (hit_m)
            return FWD_MEM;
        else if (hit_w)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/mc_hold_fsm.sv
// rtl/mc_hold_fsm.sv - counter-driven scoreboard that holds E for exactly the op latency
module mc_hold_fsm
    import hazard_pkg::*;
#(
    parameter int LAT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LAT_W-1:0] lat,
    output logic             hold
);

    localparam logic [LAT_W-1:0] ONE = {{(LAT_W-1){1'b0}}, 1'b1};

    mc_state_t        state;
    logic [LAT_W-1:0] cnt;
    logic             start_ok;

    assign start_ok = start && (lat != '0);
    // The start cycle itself is the first hold cycle, so BUSY covers the remaining lat-1.
    assign hold     = (state == MC_BUSY) || ((state == MC_IDLE) && start_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MC_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MC_IDLE: begin
                    if (start_ok) begin
                        cnt   <= lat - ONE;
                        state <= (lat == ONE) ? MC_DONE : MC_BUSY;
                    end
                end
                MC_BUSY: begin
                    cnt <= cnt - ONE;
                    if (cnt == ONE)
                        state <= MC_DONE;
                end
                MC_DONE: state <= MC_IDLE;
                default: state <= MC_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - forwarding, load-use, redirect and multi-cycle hold control
// Optional performance counters enabled by HAZARD_PERF_EN.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int         REG_ADDR_W = 5,
    parameter int         LAT_W      = 6,
    parameter logic [1:0] LOAD_SRC   = LOAD_SRC_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] A1,
    input  logic [REG_ADDR_W-1:0] A2,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic [1:0]            ResultSrcE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic [1:0]            PCSrcE,
    input  logic                  McStartE,
    input  logic [LAT_W-1:0]      McLatE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
`ifdef HAZARD_PERF_EN
    output logic [31:0]           perf_lw_stalls,
    output logic [31:0]           perf_mc_stalls,
    output logic [31:0]           perf_flushes,
`endif
    output logic                  McBusy
);

    logic hold;
    logic lw;
    logic red;
    logic m_ok;
    logic w_ok;

    mc_hold_fsm #(.LAT_W(LAT_W)) u_fsm (
        .clk   (clk),
        .rst   (rst),
        .start (McStartE),
        .lat   (McLatE),
        .hold  (hold)
    );

    assign m_ok = RegWriteM && (RdM != '0);
    assign w_ok = RegWriteW && (RdW != '0);
    assign lw   = (ResultSrcE == LOAD_SRC) && (RdE != '0) && ((RdE == A1) || (RdE == A2));
    assign red  = (PCSrcE != 2'b00);

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        McBusy    = 1'b0;
        ForwardAE = fwd_sel(m_ok && (RdM == Rs1E), w_ok && (RdW == Rs1E));
        ForwardBE = fwd_sel(m_ok && (RdM == Rs2E), w_ok && (RdW == Rs2E));
        if (rst) begin
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushM    = 1'b1;
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end else if (hold) begin
            // D is already frozen, so a load-use stall is redundant; a redirect waits for the op.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
            McBusy = 1'b1;
        end else begin
            StallF = lw;
            StallD = lw;
            FlushD = red;
            FlushE = lw || red;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lw_stalls <= '0;
            perf_mc_stalls <= '0;
            perf_flushes   <= '0;
        end else begin
            if (lw && !hold && (perf_lw_stalls != '1))
                perf_lw_stalls <= perf_lw_stalls + 32'd1;
            if (hold && (perf_mc_stalls != '1))
                perf_mc_stalls <= perf_mc_stalls + 32'd1;
            if (red && (perf_flushes != '1))
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - table-driven and sequence checks for hazard_unit_mc
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] A1, A2, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE, PCSrcE;
    logic       RegWriteM, RegWriteW, McStartE;
    logic [5:0] McLatE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lw_stalls, perf_mc_stalls, perf_flushes;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_unit_mc dut (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .McStartE(McStartE), .McLatE(McLatE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`ifdef HAZARD_PERF_EN
        .perf_lw_stalls(perf_lw_stalls), .perf_mc_stalls(perf_mc_stalls),
        .perf_flushes(perf_flushes),
`endif
        .McBusy(McBusy)
    );

    typedef struct {
        string      name;
        logic [4:0] a1, a2, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rsrc;
        logic       rwm, rww;
        logic [1:0] pcsrc;
        logic [1:0] fa, fb;
        logic       stall, fd, fe;
    } vec_t;

    vec_t vecs[10];

    // Ordered {StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy}
    localparam logic [6:0] CTRL_HOLD = 7'b1110011;
    localparam logic [6:0] CTRL_RST  = 7'b0001110;

    function automatic logic [6:0] ctrl_now();
        return {StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        A1 = 0; A2 = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        McStartE = 0; McLatE = 0;
    endtask

    task automatic set_lw(input logic on);
        ResultSrcE = on ? 2'b01 : 2'b00;
        RdE        = on ? 5'd7 : 5'd0;
        A2         = on ? 5'd7 : 5'd0;
    endtask

    // Hold McStartE for lat cycles plus DONE, then prove IDLE by restarting with lat=1.
    task automatic run_mc(input logic [5:0] lat, input logic lw_on);
        logic [6:0] idle_ctrl;
        idle_ctrl = {lw_on, lw_on, 1'b0, 1'b0, lw_on, 1'b0, 1'b0};
        set_lw(lw_on);
        McStartE = 1'b1;
        McLatE   = lat;
        for (int i = 0; i <= int'(lat); i++) begin
            @(negedge clk);
            chk($sformatf("mc lat%0d cyc%0d", lat, i), {1'b0, ctrl_now()},
                {1'b0, (i < int'(lat)) ? CTRL_HOLD : idle_ctrl});
            tick();
        end
        McLatE = 6'd1;
        @(negedge clk);
        chk($sformatf("mc lat%0d idle_restart", lat), {1'b0, ctrl_now()}, {1'b0, CTRL_HOLD});
        tick();
        McStartE = 1'b0;
        McLatE   = 6'd0;
        @(negedge clk);
        chk($sformatf("mc lat%0d done_after_restart", lat), {1'b0, ctrl_now()}, {1'b0, idle_ctrl});
        tick();
        clear_inputs();
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && McStartE === 1'b1 && PCSrcE !== 2'b00) begin
            errors++;
            $display("FAIL illegal_stimulus: McStartE with PCSrcE=%0h", PCSrcE);
        end
    end

    initial begin
        //            name          a1 a2 rs1 rs2 rdE rdM rdW rsrc rwm rww pc  fa     fb     st fd fe
        vecs[0] = '{"fwd_mem_prio", 0, 0, 5,  0,  0,  5,  5,  0,   1,  1,  0, 2'b10, 2'b00, 0, 0, 0};
        vecs[1] = '{"fwd_wb",       0, 0, 5,  0,  0,  5,  5,  0,   0,  1,  0, 2'b01, 2'b00, 0, 0, 0};
        vecs[2] = '{"fwd_x0",       0, 0, 5,  0,  0,  0,  0,  0,   1,  1,  0, 2'b00, 2'b00, 0, 0, 0};
        vecs[3] = '{"fwd_b_split",  0, 0, 3,  6,  0,  3,  6,  0,   1,  1,  0, 2'b10, 2'b01, 0, 0, 0};
        vecs[4] = '{"fwd_rs0_rd0",  0, 0, 0,  0,  0,  0,  9,  0,   1,  0,  0, 2'b00, 2'b00, 0, 0, 0};
        vecs[5] = '{"lw_a2",        0, 7, 0,  0,  7,  0,  0,  1,   0,  0,  0, 2'b00, 2'b00, 1, 0, 1};
        vecs[6] = '{"lw_rd0",       0, 0, 0,  0,  0,  0,  0,  1,   0,  0,  0, 2'b00, 2'b00, 0, 0, 0};
        vecs[7] = '{"non_load",     7, 0, 0,  0,  7,  0,  0,  2,   0,  0,  0, 2'b00, 2'b00, 0, 0, 0};
        vecs[8] = '{"redirect_lw",  0, 7, 0,  0,  7,  0,  0,  1,   0,  0,  1, 2'b00, 2'b00, 1, 1, 1};
        vecs[9] = '{"all_clear",    1, 2, 3,  4,  5,  6,  8,  0,   0,  0,  0, 2'b00, 2'b00, 0, 0, 0};

        clear_inputs();
        rst = 1'b1;
        RdM = 5'd5; Rs1E = 5'd5; RegWriteM = 1'b1;
        tick();
        @(negedge clk);
        chk("reset ctrl", {1'b0, ctrl_now()}, {1'b0, CTRL_RST});
        chk("reset fwdA", {6'd0, ForwardAE}, 8'h00);
        tick();
        clear_inputs();
        rst = 1'b0;

        foreach (vecs[i]) begin
            A1 = vecs[i].a1; A2 = vecs[i].a2; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
            RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
            ResultSrcE = vecs[i].rsrc; RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            PCSrcE = vecs[i].pcsrc;
            @(negedge clk);
            chk({vecs[i].name, " fa"}, {6'd0, ForwardAE}, {6'd0, vecs[i].fa});
            chk({vecs[i].name, " fb"}, {6'd0, ForwardBE}, {6'd0, vecs[i].fb});
            chk({vecs[i].name, " ctrl"}, {1'b0, ctrl_now()},
                {1'b0, vecs[i].stall, vecs[i].stall, 1'b0, vecs[i].fd, vecs[i].fe, 2'b00});
            tick();
        end
        clear_inputs();

        run_mc(6'd3, 1'b0);
        run_mc(6'd3, 1'b1);
        run_mc(6'd1, 1'b0);
        run_mc(6'd2, 1'b0);
        run_mc(6'd63, 1'b0);

        McStartE = 1'b1;
        McLatE   = 6'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("mc lat0 cyc%0d", i), {1'b0, ctrl_now()}, 8'h00);
            tick();
        end
        clear_inputs();

        McStartE = 1'b1; McLatE = 6'd10;
        RdM = 5'd5; Rs1E = 5'd5; RegWriteM = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("rsthold cyc%0d", i), {1'b0, ctrl_now()}, {1'b0, CTRL_HOLD});
            tick();
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("rsthold rst%0d ctrl", i), {1'b0, ctrl_now()}, {1'b0, CTRL_RST});
            chk($sformatf("rsthold rst%0d fwdA", i), {6'd0, ForwardAE}, 8'h00);
            tick();
        end
        rst = 1'b0;
        McStartE = 1'b0;
        McLatE   = 6'd0;
        @(negedge clk);
        chk("post_rst ctrl", {1'b0, ctrl_now()}, 8'h00);
        chk("post_rst fwdA", {6'd0, ForwardAE}, 8'h02);
`ifdef HAZARD_PERF_EN
        chk("post_rst perf_mc", perf_mc_stalls[7:0] | {7'd0, |perf_mc_stalls[31:8]}, 8'h00);
`endif
        tick();
        clear_inputs();
        McStartE = 1'b1; McLatE = 6'd1;
        @(negedge clk);
        chk("post_rst idle_start", {1'b0, ctrl_now()}, {1'b0, CTRL_HOLD});
        tick();
        McStartE = 1'b0; McLatE = 6'd0;
        @(negedge clk);
        chk("post_rst done", {1'b0, ctrl_now()}, 8'h00);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
